// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered long-latency
// results, forces drain slots when the buffer starves or fills, and exposes pending writes.
module wb_arbiter #(
  parameter int WIDTH_I      = 32,
  parameter int ADDR_RFILE   = 5,
  parameter int DEPTH_RFILE  = 2**ADDR_RFILE,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_wen,
  input  logic [ADDR_RFILE-1:0]         pipe_waddr,
  input  logic [WIDTH_I-1:0]            pipe_wdata,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [ADDR_RFILE-1:0]         ll_addr,
  input  logic [WIDTH_I-1:0]            ll_data,
  output logic                          w_en,
  output logic [ADDR_RFILE-1:0]         w_addr,
  output logic [WIDTH_I-1:0]            w_data,
  output logic                          stall_req,
  output logic [DEPTH_RFILE-1:0]        pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_RFILE-1:0] addr;
    logic [WIDTH_I-1:0]    data;
  } entry_t;

  typedef struct packed {
    logic                  en;
    logic                  ll;
    logic [ADDR_RFILE-1:0] addr;
    logic [WIDTH_I-1:0]    data;
  } wr_t;

  entry_t                  mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   vld_q,     vld_d;
  logic [PTR_W-1:0]        wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [STV_W-1:0]        starve_q,  starve_d;
  wr_t                     slot_q,    slot_d;
  wr_t                     out_q,     out_d;

  logic push;
  logic pop;
  logic pipe_take;

  // Pop decisions look only at registered occupancy, so a same-cycle push is never bypassed.
  // NOTE: every signal written here gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    ll_ready  = (cnt_q != CNT_FULL) && rst_n;
    push      = ll_valid && ll_ready && (ll_addr != '0);
    pipe_take = pipe_wen && (pipe_waddr != '0);
    pop       = !pipe_take && (cnt_q != '0);

    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    slot_d   = '0;
    out_d    = slot_q;

    if (pipe_take) begin
      slot_d = '{en: 1'b1, ll: 1'b0, addr: pipe_waddr, data: pipe_wdata};
    end else if (pop) begin
      slot_d = '{en: 1'b1, ll: 1'b1, addr: mem_q[rd_ptr_q].addr, data: mem_q[rd_ptr_q].data};
    end

    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if ((cnt_q == '0) || pop) begin
      starve_d = '0;
    end else if (starve_q != STV_LIMIT) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      slot_q   <= '0;
      out_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      slot_q   <= slot_d;
      out_q    <= out_d;
    end
  end

  // NOTE: buffer storage is not reset; the valid bits alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: ll_addr, data: ll_data};
    end
  end

  // A long-latency write stays pending from push until the register file commits it.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i]) pend_mask[mem_q[i].addr] = 1'b1;
    end
    if (slot_q.en && slot_q.ll) pend_mask[slot_q.addr] = 1'b1;
    if (out_q.en && out_q.ll)   pend_mask[out_q.addr]  = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign stall_req = (starve_q == STV_LIMIT) || (cnt_q == CNT_FULL);
  assign fifo_cnt  = cnt_q;
  assign w_en      = out_q.en;
  assign w_addr    = out_q.addr;
  assign w_data    = out_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued at drive time and matched
// against the register-file port by a monitor; scenario tasks check timing-specific outputs.
`timescale 1ns/1ps
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_cnt;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t pipe_q[$];
  exp_t ll_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_wen   (pipe_wen),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_addr    (ll_addr),
    .ll_data    (ll_data),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .stall_req  (stall_req),
    .pend_mask  (pend_mask),
    .fifo_cnt   (fifo_cnt)
  );

  // Monitor: pipeline writes must appear exactly two edges after sampling; other writes
  // must come from the long-latency queue in push order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
        e = pipe_q.pop_front();
        checks++;
        if (w_en !== 1'b1 || w_addr !== e.addr || w_data !== e.data) begin
          failures++;
          $display("FAIL pipe_write cyc=%0d: got en=%b addr=%0d data=%h, want addr=%0d data=%h",
                   cyc, w_en, w_addr, w_data, e.addr, e.data);
        end
      end else if (w_en === 1'b1) begin
        checks++;
        if (ll_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d: got addr=%0d data=%h, want no write",
                   cyc, w_addr, w_data);
        end else begin
          e = ll_q.pop_front();
          if (w_addr !== e.addr || w_data !== e.data) begin
            failures++;
            $display("FAIL ll_write cyc=%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                     cyc, w_addr, w_data, e.addr, e.data);
          end
        end
      end
    end
  end

  // Drive helpers, called at the falling edge; the next rising edge samples the values.
  task automatic pipe_set(input logic en, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    pipe_wen   = en;
    pipe_waddr = a;
    pipe_wdata = d;
    if (en && a != 5'd0) begin
      e.due = cyc + 2; e.addr = a; e.data = d;
      pipe_q.push_back(e);
    end
  endtask

  task automatic ll_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    ll_valid = v;
    ll_addr  = a;
    ll_data  = d;
    if (v && a != 5'd0) begin
      e.due = 0; e.addr = a; e.data = d;
      ll_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (pipe_q.size() > 0 || ll_q.size() > 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (pipe_q.size() != 0 || ll_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pipe + %0d ll writes outstanding, want 0",
               name, pipe_q.size(), ll_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pipe_set(1'b0, 5'd0, 32'd0);
    ll_set(1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (w_en !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_w: got en=%b addr=%0d data=%h, want 0/0/0", w_en, w_addr, w_data);
    end
    checks++;
    if (stall_req !== 1'b0 || pend_mask !== 32'd0 || fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_status: got stall=%b pend=%h cnt=%0d, want 0/0/0",
               stall_req, pend_mask, fifo_cnt);
    end
    checks++;
    if (ll_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ll_ready: got %b, want 0", ll_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ll_ready: got %b, want 1", ll_ready);
    end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    pipe_set(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    pipe_set(1'b0, 5'd0, 32'd0);
    checks++;
    if (pend_mask !== 32'd0) begin
      failures++;
      $display("FAIL pass_pend: got %h, want 0", pend_mask);
    end
    @(negedge clk);
    checks++;
    if (w_en !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEADBEEF || pend_mask !== 32'd0) begin
      failures++;
      $display("FAIL pass_out: got en=%b addr=%0d data=%h pend=%h, want 1/5/deadbeef/0",
               w_en, w_addr, w_data, pend_mask);
    end
    wait_drain("pass");
  endtask

  task automatic test_idle_drain();
    @(negedge clk);
    checks++;
    if (ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_ready: got %b, want 1", ll_ready);
    end
    ll_set(1'b1, 5'd7, 32'h11);
    @(negedge clk);
    ll_set(1'b0, 5'd0, 32'd0);
    checks++;
    if (pend_mask !== 32'h80 || fifo_cnt !== 3'd1) begin
      failures++;
      $display("FAIL drain_push: got pend=%h cnt=%0d, want 80/1", pend_mask, fifo_cnt);
    end
    @(negedge clk);
    checks++;
    if (w_en !== 1'b0 || pend_mask !== 32'h80) begin
      failures++;
      $display("FAIL drain_popped: got en=%b pend=%h, want 0/80", w_en, pend_mask);
    end
    @(negedge clk);
    checks++;
    if (w_en !== 1'b1 || w_addr !== 5'd7 || pend_mask !== 32'h80) begin
      failures++;
      $display("FAIL drain_write: got en=%b addr=%0d pend=%h, want 1/7/80", w_en, w_addr, pend_mask);
    end
    @(negedge clk);
    checks++;
    if (pend_mask !== 32'd0) begin
      failures++;
      $display("FAIL drain_clear: got pend=%h, want 0", pend_mask);
    end
    wait_drain("idle");
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (ll_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready%0d: got %b, want 1", k, ll_ready);
      end
      pipe_set(1'b1, 5'(10 + k), 32'hA0 + k);
      ll_set(1'b1, 5'(k + 1), 32'h100 + k);
    end
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd4 || ll_ready !== 1'b0 || stall_req !== 1'b1 || pend_mask !== 32'h1E) begin
      failures++;
      $display("FAIL fill_full: got cnt=%0d ready=%b stall=%b pend=%h, want 4/0/1/1e",
               fifo_cnt, ll_ready, stall_req, pend_mask);
    end
    pipe_set(1'b0, 5'd0, 32'd0);
    ll_set(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd3 || ll_ready !== 1'b1 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL fill_first_pop: got cnt=%0d ready=%b stall=%b, want 3/1/0",
               fifo_cnt, ll_ready, stall_req);
    end
    wait_drain("fill");
  endtask

  task automatic test_starvation();
    @(negedge clk);
    checks++;
    if (ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL starve_ready: got %b, want 1", ll_ready);
    end
    pipe_set(1'b1, 5'd20, 32'h2000);
    ll_set(1'b1, 5'd9, 32'h99);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      ll_set(1'b0, 5'd0, 32'd0);
      checks++;
      if (stall_req !== (i == 8)) begin
        failures++;
        $display("FAIL starve_stall%0d: got %b, want %b", i, stall_req, (i == 8));
      end
      if (i < 8) pipe_set(1'b1, 5'd20, 32'h2000 + i + 1);
      else       pipe_set(1'b0, 5'd0, 32'd0);
    end
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL starve_release: got stall=%b cnt=%0d, want 0/0", stall_req, fifo_cnt);
    end
    wait_drain("starve");
  endtask

  task automatic test_reg0();
    @(negedge clk);
    checks++;
    if (ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL r0_ready: got %b, want 1", ll_ready);
    end
    ll_set(1'b1, 5'd0, 32'hBAD);
    @(negedge clk);
    ll_set(1'b0, 5'd0, 32'd0);
    checks++;
    if (fifo_cnt !== 3'd0 || pend_mask !== 32'd0) begin
      failures++;
      $display("FAIL r0_ll_discard: got cnt=%0d pend=%h, want 0/0", fifo_cnt, pend_mask);
    end
    pipe_set(1'b1, 5'd21, 32'h21);
    ll_set(1'b1, 5'd3, 32'h33);
    @(negedge clk);
    ll_set(1'b0, 5'd0, 32'd0);
    pipe_set(1'b1, 5'd0, 32'hFFFF);
    checks++;
    if (fifo_cnt !== 3'd1) begin
      failures++;
      $display("FAIL r0_buffered: got cnt=%0d, want 1", fifo_cnt);
    end
    @(negedge clk);
    pipe_set(1'b0, 5'd0, 32'd0);
    checks++;
    if (fifo_cnt !== 3'd0) begin
      failures++;
      $display("FAIL r0_pipe_slot_pop: got cnt=%0d, want 0", fifo_cnt);
    end
    wait_drain("reg0");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pipe_set(1'b1, 5'd22, 32'h2200 + k);
      ll_set(1'b1, 5'(5 + k), 32'h500 + k);
    end
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd3 || pend_mask !== 32'hE0) begin
      failures++;
      $display("FAIL rmid_buffered: got cnt=%0d pend=%h, want 3/e0", fifo_cnt, pend_mask);
    end
    pipe_set(1'b0, 5'd0, 32'd0);
    ll_set(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    pipe_q.delete();
    ll_q.delete();
    @(negedge clk);
    checks++;
    if (w_en !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0 || stall_req !== 1'b0 ||
        pend_mask !== 32'd0 || fifo_cnt !== 3'd0 || ll_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_outputs: got en=%b addr=%0d data=%h stall=%b pend=%h cnt=%0d ready=%b, want all 0",
               w_en, w_addr, w_data, stall_req, pend_mask, fifo_cnt, ll_ready);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd0 || pend_mask !== 32'd0 || ll_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_after: got cnt=%0d pend=%h ready=%b, want 0/0/1",
               fifo_cnt, pend_mask, ll_ready);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_idle_drain();
    test_fill();
    test_starvation();
    test_reg0();
    test_reset_mid();
    wait_drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
